// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
//   Shared definitions for the general-purpose register bank.
//   - MODE_* : 3-bit write-operation encodings applied to the addressed register
//   - addr_width() : address width for a given register count (never below 1)
// -----------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;  // keep value, keep flag
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;  // load d, flag cleared
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b010;  // clear, flag cleared
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b011;  // +1, flag = carry
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b100;  // -1, flag = borrow
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b101;  // shift left, sin enters lsb
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b110;  // shift right, sin enters msb
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b111;  // rotate left

  // A single-register bank still needs a 1-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_next.sv
// -----------------------------------------------------------------------------
// reg_bank_next
//   Combinational next-value function for one register. Used both by the
//   write path and by the same-cycle read bypass so both always agree.
// Ports
//   r      in  WIDTH  current register value
//   d      in  WIDTH  load data
//   sin    in  1      serial-in bit for SHL/SHR
//   mode   in  3      operation select (MODE_* in reg_bank_pkg)
//   next   out WIDTH  value the register takes if written
//   c_out  out 1      carry/borrow/shifted-out bit produced by the operation
//   c_upd  out 1      1 when the operation updates the flag (all but HOLD)
// -----------------------------------------------------------------------------
module reg_bank_next
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  r,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  next,
  output logic              c_out,
  output logic              c_upd
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] shr_res;
  logic [WIDTH-1:0] rol_res;

  // A 1-bit register has no bits left to shift: shifts just take sin and a
  // rotate leaves the value as it is.
  if (WIDTH == 1) begin : g_w1
    assign shl_res = sin;
    assign shr_res = sin;
    assign rol_res = r;
  end else begin : g_wn
    assign shl_res = {r[WIDTH-2:0], sin};
    assign shr_res = {sin, r[WIDTH-1:1]};
    assign rol_res = {r[WIDTH-2:0], r[WIDTH-1]};
  end

  always_comb begin
    next  = r;
    c_out = 1'b0;
    c_upd = 1'b0;
    case (mode)
      MODE_LOAD: begin
        next  = d;
        c_upd = 1'b1;
      end
      MODE_CLR: begin
        next  = '0;
        c_upd = 1'b1;
      end
      MODE_INC: begin
        next  = r + ONE;
        c_out = &r;           // carry out only when wrapping from all-ones
        c_upd = 1'b1;
      end
      MODE_DEC: begin
        next  = r - ONE;
        c_out = ~|r;          // borrow only when wrapping from zero
        c_upd = 1'b1;
      end
      MODE_SHL: begin
        next  = shl_res;
        c_out = r[WIDTH-1];
        c_upd = 1'b1;
      end
      MODE_SHR: begin
        next  = shr_res;
        c_out = r[0];
        c_upd = 1'b1;
      end
      MODE_ROL: begin
        next  = rol_res;
        c_out = r[WIDTH-1];
        c_upd = 1'b1;
      end
      default: begin
        // MODE_HOLD: value and flag both unchanged
        next  = r;
        c_out = 1'b0;
        c_upd = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//   General-purpose CPU register set: DEPTH registers of WIDTH bits with one
//   write port (load/clear/inc/dec/shift/rotate) and two combinational read
//   ports feeding the ALU operand buses.
// Parameters
//   WIDTH      register width
//   DEPTH      number of registers (any value >= 1)
//   RESET_VAL  value every register takes on reset
//   BYPASS     1: a read port addressing the register being written shows the
//              value it is about to take, in the same cycle
// Ports
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous reset, active-high, overrides we
//   we       in  1      write enable
//   mode     in  3      write operation (MODE_* in reg_bank_pkg)
//   waddr    in  AW     write address
//   d        in  WIDTH  load data
//   sin      in  1      serial-in bit for shifts
//   raddr_a  in  AW     read address, port A
//   raddr_b  in  AW     read address, port B
//   q_a      out WIDTH  register at raddr_a (0 when out of range)
//   q_b      out WIDTH  register at raddr_b (0 when out of range)
//   zero_a   out 1      q_a == 0
//   flag_c   out 1      carry/borrow/shift-out of the last flag-producing write
// -----------------------------------------------------------------------------
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b0,
  localparam int              AW        = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MODE_W-1:0] mode,
  input  logic [AW-1:0]     waddr,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WIDTH-1:0]  q_a,
  output logic [WIDTH-1:0]  q_b,
  output logic              zero_a,
  output logic              flag_c
);

  logic [WIDTH-1:0] regs [DEPTH];

  logic [WIDTH-1:0] wr_cur;     // current value of the addressed register
  logic             wr_hit;     // waddr selects an existing register
  logic [WIDTH-1:0] wr_next;
  logic             wr_c_out;
  logic             wr_c_upd;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic             flag_c_reg;

  // Address decode and read muxes. Scanning only the implemented registers
  // makes out-of-range addresses fall through to 0 / no hit naturally.
  always_comb begin
    wr_cur   = '0;
    wr_hit   = 1'b0;
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == AW'(i)) begin
        wr_cur = regs[i];
        wr_hit = 1'b1;
      end
      if (raddr_a == AW'(i)) stored_a = regs[i];
      if (raddr_b == AW'(i)) stored_b = regs[i];
    end
  end

  reg_bank_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .r     (wr_cur),
    .d     (d),
    .sin   (sin),
    .mode  (mode),
    .next  (wr_next),
    .c_out (wr_c_out),
    .c_upd (wr_c_upd)
  );

  // Storage: one register per entry, each with its own write select.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [WIDTH-1:0] val_reg;
    logic             sel;

    assign sel = we && (waddr == AW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg <= RESET_VAL;
      end else if (sel) begin
        val_reg <= wr_next;
      end
    end

    assign regs[gi] = val_reg;
  end

  // Out-of-range writes must not touch the flag either, hence wr_hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_c_reg <= 1'b0;
    end else if (we && wr_hit && wr_c_upd) begin
      flag_c_reg <= wr_c_out;
    end
  end

  assign flag_c = flag_c_reg;

  if (BYPASS) begin : g_bypass
    // wr_hit keeps an out-of-range write from leaking onto an
    // out-of-range read, which must read as 0.
    assign q_a = (we && wr_hit && (raddr_a == waddr)) ? wr_next : stored_a;
    assign q_b = (we && wr_hit && (raddr_b == waddr)) ? wr_next : stored_b;
  end else begin : g_direct
    assign q_a = stored_a;
    assign q_b = stored_b;
  end

  assign zero_a = ~|q_a;

endmodule

// File: tb/tb_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_bank
//   Three instances share clk/rst:
//     u_a : DEPTH=4, RESET_VAL=8'h5A, BYPASS=0  (reset, load/hold, wrap, shifts)
//     u_b : DEPTH=4, RESET_VAL=0,     BYPASS=1  (same-cycle bypass)
//     u_c : DEPTH=3, RESET_VAL=0,     BYPASS=0  (out-of-range write/read)
//   Stimulus is driven 1 ns after each rising edge and the expected values for
//   the following falling edge are queued; a monitor drains the queue on every
//   falling edge and compares against the live DUT outputs.
// -----------------------------------------------------------------------------
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // instance A
  logic       a_we, a_sin, a_zero, a_flag;
  logic [2:0] a_mode;
  logic [1:0] a_waddr, a_ra, a_rb;
  logic [7:0] a_d, a_qa, a_qb;
  // instance B
  logic       b_we, b_sin, b_zero, b_flag;
  logic [2:0] b_mode;
  logic [1:0] b_waddr, b_ra, b_rb;
  logic [7:0] b_d, b_qa, b_qb;
  // instance C
  logic       c_we, c_sin, c_zero, c_flag;
  logic [2:0] c_mode;
  logic [1:0] c_waddr, c_ra, c_rb;
  logic [7:0] c_d, c_qa, c_qb;

  reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .BYPASS(1'b0)) u_a (
    .clk(clk), .rst(rst), .we(a_we), .mode(a_mode), .waddr(a_waddr), .d(a_d),
    .sin(a_sin), .raddr_a(a_ra), .raddr_b(a_rb), .q_a(a_qa), .q_b(a_qb),
    .zero_a(a_zero), .flag_c(a_flag));

  reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .BYPASS(1'b1)) u_b (
    .clk(clk), .rst(rst), .we(b_we), .mode(b_mode), .waddr(b_waddr), .d(b_d),
    .sin(b_sin), .raddr_a(b_ra), .raddr_b(b_rb), .q_a(b_qa), .q_b(b_qb),
    .zero_a(b_zero), .flag_c(b_flag));

  reg_bank #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .BYPASS(1'b0)) u_c (
    .clk(clk), .rst(rst), .we(c_we), .mode(c_mode), .waddr(c_waddr), .d(c_d),
    .sin(c_sin), .raddr_a(c_ra), .raddr_b(c_rb), .q_a(c_qa), .q_b(c_qb),
    .zero_a(c_zero), .flag_c(c_flag));

  // Observed-signal selectors
  localparam int A_QA = 0, A_QB = 1, A_ZA = 2, A_FC = 3;
  localparam int B_QA = 4, B_QB = 5, B_ZA = 6;
  localparam int C_QA = 7, C_QB = 8, C_FC = 9;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input int sel, input logic [7:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t      it;
      logic [7:0] act;
      it = sb.pop_front();
      case (it.sel)
        A_QA:    act = a_qa;
        A_QB:    act = a_qb;
        A_ZA:    act = {7'd0, a_zero};
        A_FC:    act = {7'd0, a_flag};
        B_QA:    act = b_qa;
        B_QB:    act = b_qb;
        B_ZA:    act = {7'd0, b_zero};
        C_QA:    act = c_qa;
        C_QB:    act = c_qb;
        C_FC:    act = {7'd0, c_flag};
        default: act = 8'hXX;
      endcase
      n_vec = n_vec + 1;
      if (act !== it.exp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
      end else begin
        $display("ok   %s: %02h", it.name, act);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic we, input logic [2:0] mode, input logic [1:0] wa,
                       input logic [7:0] d, input logic sin, input logic [1:0] ra,
                       input logic [1:0] rb);
    a_we = we; a_mode = mode; a_waddr = wa; a_d = d; a_sin = sin; a_ra = ra; a_rb = rb;
  endtask

  task automatic drv_b(input logic we, input logic [2:0] mode, input logic [1:0] wa,
                       input logic [7:0] d, input logic sin, input logic [1:0] ra,
                       input logic [1:0] rb);
    b_we = we; b_mode = mode; b_waddr = wa; b_d = d; b_sin = sin; b_ra = ra; b_rb = rb;
  endtask

  task automatic drv_c(input logic we, input logic [2:0] mode, input logic [1:0] wa,
                       input logic [7:0] d, input logic sin, input logic [1:0] ra,
                       input logic [1:0] rb);
    c_we = we; c_mode = mode; c_waddr = wa; c_d = d; c_sin = sin; c_ra = ra; c_rb = rb;
  endtask

  initial begin
    rst = 1'b1;
    drv_a(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    drv_b(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    drv_c(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3);

    // S1: first reset edge taken; next edge is reset with a write attempt
    step();
    rst = 1'b1;
    drv_a(1'b1, MODE_LOAD, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd1);
    chk("a_reset_q_a", A_QA, 8'h5A);
    chk("a_reset_q_b", A_QB, 8'h5A);
    chk("a_reset_flag", A_FC, 8'h00);
    chk("a_reset_zero", A_ZA, 8'h00);
    chk("b_reset_q_a", B_QA, 8'h00);
    chk("b_reset_zero", B_ZA, 8'h01);

    // S2: write during reset must have been discarded
    step();
    rst = 1'b0;
    drv_a(1'b0, MODE_HOLD, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd1);
    chk("a_rst_beats_we", A_QA, 8'h5A);

    // S3
    step();
    drv_a(1'b1, MODE_LOAD, 2'd1, 8'd13, 1'b0, 2'd1, 2'd1);
    chk("a_load_pre_edge", A_QA, 8'h5A);
    drv_b(1'b1, MODE_LOAD, 2'd0, 8'h3C, 1'b0, 2'd0, 2'd1);
    chk("b_bypass_load", B_QA, 8'h3C);
    chk("b_other_port", B_QB, 8'h00);
    chk("b_bypass_zero", B_ZA, 8'h00);
    drv_c(1'b1, MODE_LOAD, 2'd0, 8'h11, 1'b0, 2'd0, 2'd3);
    chk("c_pre_load", C_QA, 8'h00);

    // S4
    step();
    drv_a(1'b0, MODE_LOAD, 2'd1, 8'd14, 1'b0, 2'd1, 2'd1);
    chk("a_load_visible", A_QA, 8'd13);
    drv_b(1'b1, MODE_INC, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    chk("b_bypass_inc", B_QA, 8'h3D);
    drv_c(1'b1, MODE_LOAD, 2'd1, 8'h22, 1'b0, 2'd0, 2'd3);
    chk("c_r0_load", C_QA, 8'h11);

    // S5
    step();
    drv_a(1'b0, MODE_LOAD, 2'd1, 8'd14, 1'b0, 2'd1, 2'd1);
    chk("a_hold_1", A_QA, 8'd13);
    drv_b(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1);
    chk("b_stored", B_QA, 8'h3D);
    drv_c(1'b1, MODE_DEC, 2'd2, 8'h00, 1'b0, 2'd1, 2'd3);
    chk("c_r1_load", C_QA, 8'h22);

    // S6
    step();
    drv_a(1'b0, MODE_LOAD, 2'd1, 8'd14, 1'b0, 2'd1, 2'd1);
    chk("a_hold_2", A_QA, 8'd13);
    drv_c(1'b1, MODE_LOAD, 2'd3, 8'h77, 1'b0, 2'd2, 2'd3);
    chk("c_dec_wrap", C_QA, 8'hFF);
    chk("c_dec_borrow", C_FC, 8'h01);

    // S7
    step();
    drv_a(1'b1, MODE_LOAD, 2'd2, 8'hFF, 1'b0, 2'd2, 2'd1);
    chk("a_hold_3", A_QB, 8'd13);
    chk("a_r2_before", A_QA, 8'h5A);
    drv_c(1'b1, MODE_CLR, 2'd3, 8'h00, 1'b0, 2'd2, 2'd3);
    chk("c_oor_load_flag", C_FC, 8'h01);
    chk("c_oor_load_r2", C_QA, 8'hFF);

    // S8
    step();
    drv_a(1'b1, MODE_INC, 2'd2, 8'h00, 1'b0, 2'd2, 2'd1);
    chk("a_load_ff", A_QA, 8'hFF);
    chk("a_load_flag", A_FC, 8'h00);
    drv_c(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3);
    chk("c_oor_clr_flag", C_FC, 8'h01);
    chk("c_r0_kept", C_QA, 8'h11);
    chk("c_oor_read", C_QB, 8'h00);

    // S9
    step();
    drv_a(1'b1, MODE_DEC, 2'd2, 8'h00, 1'b0, 2'd2, 2'd1);
    chk("a_inc_wrap", A_QA, 8'h00);
    chk("a_inc_zero", A_ZA, 8'h01);
    chk("a_inc_carry", A_FC, 8'h01);
    drv_c(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd1, 2'd3);
    chk("c_r1_kept", C_QA, 8'h22);

    // S10
    step();
    drv_a(1'b1, MODE_DEC, 2'd2, 8'h00, 1'b0, 2'd2, 2'd1);
    chk("a_dec_wrap", A_QA, 8'hFF);
    chk("a_dec_borrow", A_FC, 8'h01);
    chk("a_dec_nonzero", A_ZA, 8'h00);

    // S11
    step();
    drv_a(1'b1, MODE_LOAD, 2'd3, 8'b1000_0001, 1'b0, 2'd3, 2'd2);
    chk("a_dec_plain", A_QB, 8'hFE);
    chk("a_dec_noborrow", A_FC, 8'h00);

    // S12
    step();
    drv_a(1'b1, MODE_SHL, 2'd3, 8'h00, 1'b0, 2'd3, 2'd2);
    chk("a_load_81", A_QA, 8'b1000_0001);

    // S13
    step();
    drv_a(1'b1, MODE_SHR, 2'd3, 8'h00, 1'b1, 2'd3, 2'd2);
    chk("a_shl", A_QA, 8'b0000_0010);
    chk("a_shl_c", A_FC, 8'h01);

    // S14
    step();
    drv_a(1'b1, MODE_ROL, 2'd3, 8'h00, 1'b0, 2'd3, 2'd2);
    chk("a_shr", A_QA, 8'b1000_0001);
    chk("a_shr_c", A_FC, 8'h00);

    // S15
    step();
    drv_a(1'b1, MODE_HOLD, 2'd3, 8'hAA, 1'b1, 2'd3, 2'd1);
    chk("a_rol", A_QA, 8'b0000_0011);
    chk("a_rol_c", A_FC, 8'h01);
    chk("a_r1_kept", A_QB, 8'd13);

    // S16
    step();
    drv_a(1'b0, MODE_HOLD, 2'd0, 8'h00, 1'b0, 2'd3, 2'd1);
    chk("a_hold_mode", A_QA, 8'b0000_0011);
    chk("a_hold_mode_c", A_FC, 8'h01);

    // Let the monitor drain, with a bound
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_vec  = n_vec + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
